// File: rtl/score_logger.sv
// score_logger: write-side controller for the 32-entry score storage.
// Zero-fills the storage, logs game-over scores, and flags new highs.
module score_logger (
  input  logic       clock,
  input  logic       reset,
  input  logic       game_over,
  input  logic [9:0] score,
  input  logic       clear_req,
  input  logic [9:0] largest_value,
  output logic [4:0] address,
  output logic [9:0] data,
  output logic       wren,
  output logic       busy,
  output logic       new_high,
  output logic [5:0] entries
);

  typedef enum logic [1:0] {
    INIT,
    CLEAR,
    IDLE,
    WRITE
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [4:0] wr_ptr;
  logic [4:0] clr_idx;
  logic [9:0] score_q;
  logic       go_q;
  logic       go_pending;
  logic       clr_pending;
  logic       go_edge;
  logic       want_clear;

  assign go_edge    = game_over & ~go_q;
  assign want_clear = clear_req | clr_pending;

  // State register; reset restarts the full zero-fill.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= state_n;
  end

  // Next state and storage write port, decoded from the current state.
  always_comb begin
    state_n = state;
    address = 5'd0;
    data    = 10'd0;
    wren    = 1'b0;
    busy    = 1'b1;
    unique case (state)
      INIT: begin
        state_n = CLEAR;
      end
      CLEAR: begin
        wren    = 1'b1;
        address = clr_idx;
        if (clr_idx == 5'd31) state_n = IDLE;
      end
      IDLE: begin
        busy    = 1'b0;
        address = wr_ptr;
        if (want_clear)                 state_n = CLEAR;
        else if (go_pending || go_edge) state_n = WRITE;
      end
      WRITE: begin
        wren    = 1'b1;
        address = wr_ptr;
        data    = score_q;
        state_n = IDLE;
      end
    endcase
  end

  // Pointers, occupancy, pending events and the new-high pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr      <= 5'd0;
      clr_idx     <= 5'd0;
      entries     <= 6'd0;
      score_q     <= 10'd0;
      go_q        <= 1'b0;
      go_pending  <= 1'b0;
      clr_pending <= 1'b0;
      new_high    <= 1'b0;
    end else begin
      go_q     <= game_over;
      new_high <= 1'b0;
      unique case (state)
        INIT: begin
          if (go_edge) begin
            go_pending <= 1'b1;
            score_q    <= score;
          end
        end
        CLEAR: begin
          clr_idx <= clr_idx + 5'd1;
          if (clr_idx == 5'd31) begin
            wr_ptr  <= 5'd0;
            entries <= 6'd0;
          end
          if (go_edge) begin
            go_pending <= 1'b1;
            score_q    <= score;
          end
        end
        IDLE: begin
          if (want_clear) begin
            clr_idx     <= 5'd0;
            go_pending  <= 1'b0;
            clr_pending <= 1'b0;
          end else if (go_pending) begin
            go_pending <= 1'b0;
          end else if (go_edge) begin
            score_q <= score;
          end
        end
        WRITE: begin
          wr_ptr <= wr_ptr + 5'd1;
          if (entries != 6'd32) entries <= entries + 6'd1;
          new_high <= (entries == 6'd0) || (score_q > largest_value);
          if (clear_req) clr_pending <= 1'b1;
          if (go_edge) begin
            go_pending <= 1'b1;
            score_q    <= score;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_logger.sv
// tb_score_logger: directed and random game sequences against a
// reference model of the stored scores.
module tb_score_logger;

  logic       clk;
  logic       rst;
  logic       go;
  logic [9:0] sc;
  logic       clr;
  logic [9:0] lv;
  logic [4:0] addr;
  logic [9:0] dat;
  logic       wren;
  logic       busy;
  logic       nh;
  logic [5:0] ent;

  int n_assert;
  int n_fail;

  logic [9:0] store [32];
  logic [9:0] ref_mem [32];
  int         ref_ptr;
  int         ref_cnt;

  score_logger dut (
    .clock        (clk),
    .reset        (rst),
    .game_over    (go),
    .score        (sc),
    .clear_req    (clr),
    .largest_value(lv),
    .address      (addr),
    .data         (dat),
    .wren         (wren),
    .busy         (busy),
    .new_high     (nh),
    .entries      (ent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage: commits on wren, reports its maximum combinationally.
  always @(posedge clk) begin
    if (wren) store[addr] <= dat;
  end

  always_comb begin
    lv = 10'd0;
    for (int i = 0; i < 32; i++)
      if (store[i] > lv) lv = store[i];
  end

  function automatic int ref_max();
    int m;
    m = 0;
    for (int i = 0; i < 32; i++)
      if (int'(ref_mem[i]) > m) m = int'(ref_mem[i]);
    return m;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) ref_mem[i] = 10'd0;
    ref_ptr = 0;
    ref_cnt = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_check();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_wren", 32'(wren), 32'd0);
    chk("idle_entries", 32'(ent), 32'(ref_cnt));
    chk("idle_addr", 32'(addr), 32'(ref_ptr));
  endtask

  // Checks n consecutive clear cycles starting at the current negedge.
  task automatic expect_clear(input int n, input int inj_at,
                              input logic [9:0] inj_s);
    for (int i = 0; i < n; i++) begin
      chk("clr_wren", 32'(wren), 32'd1);
      chk("clr_addr", 32'(addr), 32'(i));
      chk("clr_data", 32'(dat), 32'd0);
      chk("clr_busy", 32'(busy), 32'd1);
      if (i == inj_at) begin
        go = 1'b1;
        sc = inj_s;
      end else if (i == inj_at + 1) begin
        go = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  // Current negedge is the write cycle for score s.
  task automatic expect_write(input logic [9:0] s);
    logic exp_nh;
    int   cap;
    exp_nh = (ref_cnt == 0) || (int'(s) > ref_max());
    chk("wr_wren", 32'(wren), 32'd1);
    chk("wr_addr", 32'(addr), 32'(ref_ptr));
    chk("wr_data", 32'(dat), 32'(s));
    chk("wr_busy", 32'(busy), 32'd1);
    ref_mem[ref_ptr] = s;
    ref_ptr = (ref_ptr + 1) % 32;
    cap = ref_cnt + 1;
    ref_cnt = (cap > 32) ? 32 : cap;
    @(negedge clk);
    chk("new_high", 32'(nh), 32'(exp_nh));
    chk("entries", 32'(ent), 32'(ref_cnt));
    chk("post_wren", 32'(wren), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
  endtask

  task automatic game(input logic [9:0] s, input int hold);
    go = 1'b1;
    sc = s;
    @(negedge clk);
    if (hold <= 1) go = 1'b0;
    expect_write(s);
    for (int i = 2; i < hold; i++) begin
      @(negedge clk);
      chk("hold_wren", 32'(wren), 32'd0);
      chk("hold_nh", 32'(nh), 32'd0);
    end
    if (hold > 1) begin
      go = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_data", 32'(dat), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_entries", 32'(ent), 32'd0);
    chk("rst_nh", 32'(nh), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("init_wren", 32'(wren), 32'd0);
    chk("init_busy", 32'(busy), 32'd1);
    model_clear();
    @(negedge clk);
    expect_clear(32, -1, 10'd0);
    idle_check();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    go  = 1'b0;
    sc  = 10'd0;
    clr = 1'b0;
    @(negedge clk);
    do_reset();

    game(10'd150, 1);
    game(10'd100, 1);
    game(10'd150, 10);
    @(negedge clk);
    idle_check();

    // Clear and game-over edge in the same idle cycle: clear only.
    clr = 1'b1;
    go  = 1'b1;
    sc  = 10'd500;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    expect_clear(32, -1, 10'd0);
    idle_check();
    @(negedge clk);
    idle_check();
    go = 1'b0;
    @(negedge clk);
    idle_check();

    for (int i = 1; i <= 33; i++) game(10'(i), 1);

    repeat (40) begin
      game(10'($urandom_range(0, 1023)),
           ($urandom_range(0, 3) == 0) ? $urandom_range(2, 5) : 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Game edge during clear is held and written after it.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    expect_clear(32, 5, 10'd77);
    idle_check();
    @(negedge clk);
    expect_write(10'd77);

    game(10'd300, 1);

    // Reset in the middle of a clear restarts the full sequence.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    expect_clear(10, -1, 10'd0);
    chk("mid_addr", 32'(addr), 32'd10);
    do_reset();

    repeat (10) game(10'($urandom_range(0, 1023)), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/score_logger.md
# score_logger

Write-side controller for the 32-entry game-over score storage. It turns game-over events from the game FSM into single-cycle writes of the final score into the storage's circular slots. It also zero-fills the storage after reset and on request, and flags a new high score by comparing against the storage's `largest_value` output. Sits between the game control FSM and the score storage.

## Interface

Parameters: none. Depth is fixed at 32 entries, score width at 10 bits.

- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `game_over` in 1: level from the game FSM. A rising edge marks one game end.
- `score` in 10: final score, sampled on the `game_over` rising edge.
- `clear_req` in 1: request to zero the storage. Level or pulse; sampled each cycle.
- `largest_value` in 10: current maximum from the storage (combinational on the storage side).
- `address` out 5: storage write address.
- `data` out 10: storage write data.
- `wren` out 1: storage write enable.
- `busy` out 1: high in INIT, CLEAR, WRITE.
- `new_high` out 1: one-cycle pulse when the just-written score exceeds all prior stored scores.
- `entries` out 6: number of valid scores, 0..32, saturating.

## Operation

States: INIT, CLEAR, IDLE, WRITE.

- **Reset (asynchronous):**
  - state = INIT; `wr_ptr` = 0; `clr_idx` = 0; `entries` = 0.
  - `new_high` = 0; pending flags cleared; `game_over` history register = 0.
  - Outputs: `address`=0, `data`=0, `wren`=0, `busy`=1.
- **INIT:** one cycle, `wren`=0, then go to CLEAR.
- **CLEAR:**
  - `wren`=1, `address`=`clr_idx`, `data`=0.
  - `clr_idx` increments every cycle.
  - After `clr_idx`=31 is written: `wr_ptr`=0, `entries`=0, go to IDLE.
  - `clear_req` is ignored while in CLEAR.
- **IDLE:** `wren`=0, `address`=`wr_ptr`, `data`=0. Priority, highest first:
  1. `clear_req` or `clear_pending`: `clr_idx`=0, go to CLEAR.
  2. `go_pending`: go to WRITE using the latched score.
  3. `game_over` rising edge (`game_over`=1, history=0): latch `score`, go to WRITE.
  - A simultaneous clear and game-over edge: clear wins and the game-over event is discarded.
- **WRITE:** one cycle.
  - `wren`=1, `address`=`wr_ptr`, `data`=`score_q`.
  - At the end of the cycle:
    - `wr_ptr` = `wr_ptr`+1, wrapping 31→0.
    - `entries` = min(`entries`+1, 32).
    - `new_high` registered as (`entries`==0) OR (`score_q` > `largest_value`), using `largest_value` as seen during the WRITE cycle, i.e. before the commit.
  - Go to IDLE.
- **Events while busy:**
  - A `game_over` rising edge in INIT/CLEAR/WRITE sets `go_pending` and latches `score`. Only one event is held; a later edge overwrites the score.
  - `clear_req` during WRITE sets `clear_pending`.
  - Pending flags clear when serviced. A clear services and discards any `go_pending`.
- The `game_over` history register updates every cycle in every state, so a held-high level produces exactly one event.
- Comparison is unsigned 10-bit. An equal score does not set `new_high` unless `entries`==0.
- Wrap-around: the 33rd write overwrites slot 0; `entries` stays 32.

## Timing

- **Game-over edge in IDLE at clock edge k:**
  - WRITE occupies cycle k→k+1 with `wren`=1.
  - The storage commits at edge k+1.
  - `new_high`, `entries` and `wr_ptr` update at edge k+1; `new_high` is high for exactly cycle k+1→k+2.
  - `busy` is high for exactly one cycle.
  - Minimum spacing between serviced games: 2 cycles.
- **After reset deassertion:**
  - 1 INIT cycle, then 32 CLEAR cycles (`wren`=1, addresses 0..31 ascending), then IDLE.
  - `busy` is high for 33 cycles after the first edge.
- **`clear_req` in IDLE at edge k:** CLEAR occupies 32 cycles starting after edge k; IDLE is re-entered after edge k+32.
- **Pending game:** WRITE follows one IDLE cycle after `busy` drops.
- **`reset` mid-operation (e.g. mid-CLEAR or during WRITE):** immediate return to INIT; `wren` drops asynchronously; pending events are lost; the full clear repeats.

## Test plan

- **Reset then idle:** `wren` high for 32 consecutive cycles, `address` 0..31, `data`=0. Then `busy`=0 and `entries`=0.
- **Single game, score=150:** one `wren` cycle at `address` 0 with `data` 150. `entries`=1 and `new_high` pulses once. A second game with score=100 writes `address` 1, `new_high`=0, `entries`=2.
- **Wrap-around:** 33 games with scores 1..33. The 33rd write goes to `address` 0 with `data` 33; `entries` stays 32; `new_high` pulses on every write.
- **`game_over` held high for 10 cycles:** exactly one write. A score equal to the current max (150 again) gives `new_high`=0.
- **Game-over edge during CLEAR, score=77:** write of 77 at `address` 0 one cycle after CLEAR ends; `entries`=1.
- **`clear_req` and game-over edge in the same IDLE cycle:** CLEAR only, no write, `entries`=0. Reset asserted mid-CLEAR (at `clr_idx`=10) restarts INIT and the full 32-address clear.
